signal_conflict_monitor: RTL

//  Independent conflict monitor (MMU) that reads the ten color_e signal outputs of the intersection

---
 rtl/signal_conflict_monitor.sv | 133 +++++++++++++
 1 files changed

// File: rtl/signal_conflict_monitor.sv
// signal_conflict_monitor: conflict monitor latching faults and forcing cabinet flash; FAULT_COUNT_EN adds fault_count
package traffic_signal_colors_pkg;
  typedef enum logic [1:0] {RED, YELLOW, GREEN, FLASHING} color_e;
endpackage

module signal_conflict_monitor
  import traffic_signal_colors_pkg::*;
#(
  parameter int MIN_YELLOW       = 5,
  parameter int CONFLICT_PERSIST = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  color_e     signal_sb,
  input  color_e     signal_sb_turn,
  input  color_e     signal_nb,
  input  color_e     signal_nb_turn,
  input  color_e     signal_wb,
  input  color_e     signal_wb_turn,
  input  color_e     signal_eb,
  input  color_e     signal_eb_turn,
  input  color_e     ped_signal_ns,
  input  color_e     ped_signal_ew,
  input  logic       clear_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       force_flash
`ifdef FAULT_COUNT_EN
  ,
  output logic [7:0] fault_count
`endif
);
  localparam int PW = $clog2(CONFLICT_PERSIST + 1);
  localparam int YW = $clog2(MIN_YELLOW + 1);
  typedef enum logic [1:0] {MONITOR, PENDING, FAULT} state_e;
  function automatic logic act(color_e c);
    return c == GREEN || c == YELLOW;
  endfunction
  state_e state, state_nx;
  logic [PW-1:0] pcnt, pcnt_nx;
  logic [2:0] code, code_nx;
  color_e veh [8];
  color_e prev [8];
  logic [YW-1:0] ycnt [8];
  logic c1, c2, c3, short_y, any_flash, all_flash, clr;
  assign veh = '{signal_sb, signal_sb_turn, signal_nb, signal_nb_turn,
                 signal_wb, signal_wb_turn, signal_eb, signal_eb_turn};
  assign c1 = (act(signal_sb) | act(signal_sb_turn) | act(signal_nb) | act(signal_nb_turn) | act(ped_signal_ns)) &
              (act(signal_wb) | act(signal_wb_turn) | act(signal_eb) | act(signal_eb_turn) | act(ped_signal_ew));
  assign c2 = (act(signal_sb_turn) & act(signal_nb)) | (act(signal_nb_turn) & act(signal_sb)) |
              (act(signal_wb_turn) & act(signal_eb)) | (act(signal_eb_turn) & act(signal_wb));
  assign c3 = (act(ped_signal_ns) & (act(signal_sb_turn) | act(signal_nb_turn))) |
              (act(ped_signal_ew) & (act(signal_wb_turn) | act(signal_eb_turn)));
  assign force_flash = fault;
  assign clr = state == FAULT && state_nx == MONITOR;
  // per-head short-yellow detection and flash uniformity across all ten heads
  always_comb begin
    short_y = 1'b0;
    any_flash = ped_signal_ns == FLASHING || ped_signal_ew == FLASHING;
    all_flash = ped_signal_ns == FLASHING && ped_signal_ew == FLASHING;
    for (int i = 0; i < 8; i++) begin
      short_y |= prev[i] != FLASHING && veh[i] != FLASHING &&
                 ((prev[i] == GREEN && veh[i] == RED) ||
                  (prev[i] == YELLOW && veh[i] != YELLOW && (veh[i] == GREEN || ycnt[i] < YW'(MIN_YELLOW))));
      any_flash |= veh[i] == FLASHING;
      all_flash &= veh[i] == FLASHING;
    end
    code = c1 ? 3'd1 : c2 ? 3'd2 : c3 ? 3'd3 : short_y ? 3'd4 : (any_flash && !all_flash) ? 3'd5 : 3'd0;
  end
  // monitor/pending/fault next-state; the code is captured only on entry into FAULT
  always_comb begin
    state_nx = state;
    pcnt_nx = pcnt;
    code_nx = fault_code;
    unique case (state)
      MONITOR:
        if (code == 3'd4 || (code != 3'd0 && CONFLICT_PERSIST == 1)) begin
          state_nx = FAULT;
          code_nx = code;
        end else if (code != 3'd0) begin
          state_nx = PENDING;
          pcnt_nx = PW'(1);
        end
      PENDING:
        if (code == 3'd0) begin
          state_nx = MONITOR;
          pcnt_nx = '0;
        end else if (pcnt + PW'(1) == PW'(CONFLICT_PERSIST)) begin
          state_nx = FAULT;
          code_nx = code;
          pcnt_nx = '0;
        end else pcnt_nx = pcnt + PW'(1);
      default:
        if (clear_fault && code == 3'd0) begin
          state_nx = MONITOR;
          code_nx = 3'd0;
          pcnt_nx = '0;
        end
    endcase
  end
  // state, persist counter and registered fault outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= MONITOR;
      pcnt <= '0;
      fault <= 1'b0;
      fault_code <= 3'd0;
    end else begin
      state <= state_nx;
      pcnt <= pcnt_nx;
      fault <= state_nx == FAULT;
      fault_code <= code_nx;
    end
  // previous colours track inputs; yellow counters saturate and are cleared when a fault is cleared
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        prev[i] <= FLASHING;
        ycnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        prev[i] <= veh[i];
        ycnt[i] <= (clr || veh[i] != YELLOW) ? '0 : ycnt[i] == YW'(MIN_YELLOW) ? ycnt[i] : ycnt[i] + YW'(1);
      end
    end
`ifdef FAULT_COUNT_EN
  // saturating count of FAULT entries, cleared only by reset
  always_ff @(posedge clk or posedge reset)
    if (reset) fault_count <= 8'd0;
    else if (state_nx == FAULT && state != FAULT && fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
`endif
endmodule
